// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, default geometry and helpers for the life grid streamer
// Contents:
//   life_state_t    frame FSM states (IDLE, LOAD, STREAM, DONE)
//   DEF_*           default grid geometry
//   beats_per_row() output beats needed to cover one grid row
//   idx_bits()      counter width for an index range, never below 1 bit
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } life_state_t;

    localparam int DEF_WIDTH     = 1200;
    localparam int DEF_HEIGHT    = 1920;
    localparam int DEF_BEAT_BITS = 16;

    function automatic int beats_per_row(input int width, input int beat_bits);
        return width / beat_bits;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/life_raster_counter.sv
// rtl/life_raster_counter.sv - row/column raster position of the beat currently presented
// Ports:
//   clk, reset      clock, asynchronous active-high reset (position -> 0,0)
//   advance         current beat accepted; step to the next raster position
//   row, col        current position
//   last_col        current beat is the last of its row
//   last_beat       current beat is the last of the frame
//   next_row/col    position that follows the current one (wraps to 0,0 after the frame)
//   next_last_col   the following position is the last of its row
module life_raster_counter
    import life_pkg::*;
#(
    parameter int COLS = 2,
    parameter int ROWS = 4,
    localparam int COL_W = idx_bits(COLS),
    localparam int ROW_W = idx_bits(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             last_beat,
    output logic [ROW_W-1:0] next_row,
    output logic [COL_W-1:0] next_col,
    output logic             next_last_col
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    assign last_col  = (col == LAST_COL);
    assign last_beat = last_col && (row == LAST_ROW);

    // Wrapping fully after the final beat leaves the counter at 0,0, so the
    // next frame starts at the origin without an explicit clear.
    always_comb begin
        next_col = last_col ? '0 : col + COL_W'(1);
        next_row = row;
        if (last_beat) begin
            next_row = '0;
        end else if (last_col) begin
            next_row = row + ROW_W'(1);
        end
        next_last_col = (next_col == LAST_COL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= next_row;
            col <= next_col;
        end
    end

endmodule

// File: rtl/life_grid_streamer.sv
// rtl/life_grid_streamer.sv - streams a life grid out as row-major beats of BEAT_BITS cells
// Build option: LIFE_STREAM_SNAPSHOT_EN - freeze grid_in into a frame register in LOAD
//   and stream every beat from that copy; otherwise each beat samples grid_in live.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   grid_in         grid, bit [y][x] = cell (x,y)
//   frame_req       one-cycle request to stream a frame (ignored while a frame is active)
//   busy            frame in LOAD or STREAM
//   tvalid/tready   beat handshake
//   tdata           BEAT_BITS cells, bit k = grid[row][col*BEAT_BITS+k]
//   tuser           first beat of frame
//   tlast           last beat of a row
//   frame_done      one-cycle pulse after the final beat is accepted
//   frame_count     completed frames, wrapping
module life_grid_streamer
    import life_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int BEAT_BITS = DEF_BEAT_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [HEIGHT-1:0][WIDTH-1:0]  grid_in,
    input  logic                          frame_req,
    output logic                          busy,
    output logic                          tvalid,
    input  logic                          tready,
    output logic [BEAT_BITS-1:0]          tdata,
    output logic                          tuser,
    output logic                          tlast,
    output logic                          frame_done,
    output logic [15:0]                   frame_count
);

    localparam int COLS  = beats_per_row(WIDTH, BEAT_BITS);
    localparam int COL_W = idx_bits(COLS);
    localparam int ROW_W = idx_bits(HEIGHT);

    life_state_t      state;
    logic             advance;
    logic [ROW_W-1:0] row, next_row, sel_row;
    logic [COL_W-1:0] col, next_col, sel_col;
    logic             last_col, last_beat, next_last_col;
    logic [WIDTH-1:0] src_row;
    logic [BEAT_BITS-1:0] beat;

    assign advance = (state == ST_STREAM) && tvalid && tready;

    life_raster_counter #(
        .COLS (COLS),
        .ROWS (HEIGHT)
    ) u_raster (
        .clk           (clk),
        .reset         (reset),
        .advance       (advance),
        .row           (row),
        .col           (col),
        .last_col      (last_col),
        .last_beat     (last_beat),
        .next_row      (next_row),
        .next_col      (next_col),
        .next_last_col (next_last_col)
    );

    // On a transfer the following beat is fetched in the same cycle so the
    // stream has no bubbles; otherwise (LOAD) the counter already sits at 0,0.
    assign sel_row = advance ? next_row : row;
    assign sel_col = advance ? next_col : col;

`ifdef LIFE_STREAM_SNAPSHOT_EN
    logic [HEIGHT-1:0][WIDTH-1:0] frame_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_reg <= '0;
        end else if (state == ST_LOAD) begin
            frame_reg <= grid_in;
        end
    end

    // The first beat is registered in LOAD alongside the copy, so it reads
    // grid_in directly; it is the same value the copy captures.
    assign src_row = (state == ST_STREAM) ? frame_reg[sel_row] : grid_in[sel_row];
`else
    assign src_row = grid_in[sel_row];
`endif

    assign beat = src_row[int'(sel_col) * BEAT_BITS +: BEAT_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tvalid      <= 1'b0;
            tdata       <= '0;
            tuser       <= 1'b0;
            tlast       <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_req) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tdata  <= beat;
                    tvalid <= 1'b1;
                    tuser  <= 1'b1;
                    tlast  <= last_col;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (tvalid && tready) begin
                        tuser <= 1'b0;
                        if (last_beat) begin
                            tvalid      <= 1'b0;
                            tlast       <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            state       <= ST_DONE;
                        end else begin
                            tdata <= beat;
                            tlast <= next_last_col;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_grid_streamer.sv
// tb/tb_life_grid_streamer.sv - scoreboard bench for life_grid_streamer on a 32x4 grid, 16-cell beats
module tb_life_grid_streamer;

    localparam int W  = 32;
    localparam int H  = 4;
    localparam int BB = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [H-1:0][W-1:0] grid_in;
    logic              frame_req = 1'b0;
    logic              busy;
    logic              tvalid;
    logic              tready = 1'b1;
    logic [BB-1:0]     tdata;
    logic              tuser;
    logic              tlast;
    logic              frame_done;
    logic [15:0]       frame_count;

    always #5 clk = ~clk;

    life_grid_streamer #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .BEAT_BITS (BB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .grid_in     (grid_in),
        .frame_req   (frame_req),
        .busy        (busy),
        .tvalid      (tvalid),
        .tready      (tready),
        .tdata       (tdata),
        .tuser       (tuser),
        .tlast       (tlast),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t e_beat;
    beat_t held;
    int    accepted = 0;
    int    done_pulses = 0;
    logic  prev_stall = 1'b0;
    logic  prev_done = 1'b0;
    int    saved_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected beat per handshake, checks stall stability
    // and the frame_done pulse.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall && tvalid) begin
                check("stall_hold", {14'd0, tdata, tuser, tlast}, {14'd0, held});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat_data", {16'd0, tdata}, {16'd0, e_beat.data});
                    check("beat_user", {31'd0, tuser}, {31'd0, e_beat.user});
                    check("beat_last", {31'd0, tlast}, {31'd0, e_beat.last});
                end
                accepted++;
            end
            prev_stall = tvalid && !tready;
            held       = {tdata, tuser, tlast};
            if (frame_done) begin
                done_pulses++;
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("done_queue_empty", exp_q.size(), 32'd0);
            end
            prev_done = frame_done;
        end
    end

    task automatic push(input logic [15:0] d, input logic u, input logic l);
        exp_q.push_back({d, u, l});
    endtask

    task automatic push_glider();
        push(16'h0002, 1'b1, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0004, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0007, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
    endtask

    task automatic set_glider();
        grid_in = '0;
        grid_in[0][1] = 1'b1;
        grid_in[1][2] = 1'b1;
        grid_in[2][0] = 1'b1;
        grid_in[2][1] = 1'b1;
        grid_in[2][2] = 1'b1;
    endtask

    // Returns just after the edge that samples the request (DUT now in LOAD).
    task automatic pulse_req();
        @(posedge clk);
        #1 frame_req = 1'b1;
        @(posedge clk);
        #1 frame_req = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int start;
        bit seen;
        start = done_pulses;
        seen  = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_pulses != start) seen = 1'b1;
        end
        check("frame_done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_accepted(input int n, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge clk);
            #1;
            if (accepted >= n) seen = 1'b1;
        end
        check("beats_reached", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        grid_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tuser", {31'd0, tuser}, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_tdata", {16'd0, tdata}, 32'd0);
        check("rst_count", {16'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_tvalid", {31'd0, tvalid}, 32'd0);

        // Glider, sink always ready, with first-beat latency
        set_glider();
        accepted = 0;
        push_glider();
        pulse_req();
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_tvalid", {31'd0, tvalid}, 32'd0);
        @(posedge clk);
        #1;
        check("first_tvalid", {31'd0, tvalid}, 32'd1);
        check("first_tuser", {31'd0, tuser}, 32'd1);
        wait_done(40);
        check("f1_beats", accepted, 32'd8);
        check("f1_count", {16'd0, frame_count}, 32'd1);
        check("f1_done_low", {31'd0, frame_done}, 32'd0);
        check("f1_busy_low", {31'd0, busy}, 32'd0);

        // Three-cycle stall on beat 3
        accepted = 0;
        push_glider();
        pulse_req();
        wait_accepted(2, 40);
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tready = 1'b1;
        wait_done(40);
        check("f2_beats", accepted, 32'd8);
        check("f2_count", {16'd0, frame_count}, 32'd2);

        // Second request during STREAM is dropped
        accepted = 0;
        push_glider();
        pulse_req();
        wait_accepted(3, 40);
        frame_req = 1'b1;
        @(posedge clk);
        #1 frame_req = 1'b0;
        wait_done(40);
        repeat (6) @(posedge clk);
        #1;
        check("f3_beats", accepted, 32'd8);
        check("f3_busy", {31'd0, busy}, 32'd0);
        check("f3_tvalid", {31'd0, tvalid}, 32'd0);
        check("f3_count", {16'd0, frame_count}, 32'd3);

        // Reset while beat 5 is presented
        accepted = 0;
        push_glider();
        pulse_req();
        wait_accepted(4, 40);
        saved_done = done_pulses;
        #2 reset = 1'b1;
        #1;
        check("abort_tvalid", {31'd0, tvalid}, 32'd0);
        check("abort_count", {16'd0, frame_count}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_pulses, saved_done);

        // Restart after abort begins at the tuser beat
        accepted = 0;
        push_glider();
        pulse_req();
        @(posedge clk);
        #1;
        check("restart_tuser", {31'd0, tuser}, 32'd1);
        check("restart_tdata", {16'd0, tdata}, 32'h0002);
        wait_done(40);
        check("f4_beats", accepted, 32'd8);
        check("f4_count", {16'd0, frame_count}, 32'd1);

        // Cells in the upper column of rows 0 and 3
        grid_in = '0;
        grid_in[0][16] = 1'b1;
        grid_in[3][31] = 1'b1;
        accepted = 0;
        push(16'h0000, 1'b1, 1'b0);
        push(16'h0001, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h8000, 1'b0, 1'b1);
        pulse_req();
        wait_done(40);
        check("f5_beats", accepted, 32'd8);
        check("f5_count", {16'd0, frame_count}, 32'd2);

        // grid_in cleared right after the first beat is registered
        set_glider();
        accepted = 0;
`ifdef LIFE_STREAM_SNAPSHOT_EN
        push_glider();
`else
        push(16'h0002, 1'b1, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b1);
`endif
        pulse_req();
        @(posedge clk);
        #1 grid_in = '0;
        wait_done(40);
        check("f6_beats", accepted, 32'd8);
        check("f6_count", {16'd0, frame_count}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
